sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_sram_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-port (A/B) round-robin arbiter onto a single-port SRAM, with a full-memory zero-fill engine.
// Write ack 2 cycles after grant-sample, read ack 3 cycles; requesters wait (Req held) while busy or clearing.
module sram_arbiter (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        A_Req,
    input  logic        A_Rw,
    input  logic [14:0] A_Addr,
    input  logic [7:0]  A_Wdata,
    output logic        A_Ack,
    output logic [7:0]  A_Rdata,
    input  logic        B_Req,
    input  logic        B_Rw,
    input  logic [14:0] B_Addr,
    input  logic [7:0]  B_Wdata,
    output logic        B_Ack,
    output logic [7:0]  B_Rdata,
    input  logic        Clr_start,
    output logic        Clr_busy,
    output logic        Clr_done,
    output logic        Sram_En,
    output logic        Sram_Rw,
    output logic [14:0] Sram_Addr,
    output logic [7:0]  Sram_Data_in,
    input  logic [7:0]  Sram_Data_out
);

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        RWAIT,
        DONE,
        CLEAR
    } state_t;

    localparam logic [14:0] LAST_ADDR = 15'h7FFF;

    state_t      r_state, w_state_nxt;
    logic        r_sel_b, w_sel_b;
    logic        r_last_b, w_last_b;
    logic [14:0] r_cnt, w_cnt;
    logic        r_clr_pend, w_clr_pend;
    logic        r_clr_busy, w_clr_busy;
    logic        r_clr_done, w_clr_done;
    logic        r_sram_en, w_sram_en;
    logic        r_sram_rw, w_sram_rw;
    logic [14:0] r_sram_addr, w_sram_addr;
    logic [7:0]  r_sram_din, w_sram_din;
    logic        r_a_ack, w_a_ack;
    logic        r_b_ack, w_b_ack;
    logic [7:0]  r_a_rdata, w_a_rdata;
    logic [7:0]  r_b_rdata, w_b_rdata;
    logic        w_clr_req;

    // A clear request arriving while already clearing is dropped.
    assign w_clr_req = Clr_start && (r_state != CLEAR);

    always_ff @(posedge Clk) begin
        if (Rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_b     = r_sel_b;
        w_last_b    = r_last_b;
        w_cnt       = r_cnt;
        w_clr_pend  = r_clr_pend | w_clr_req;
        w_clr_busy  = r_clr_busy | w_clr_req;
        w_clr_done  = 1'b0;
        w_sram_en   = 1'b0;
        w_sram_rw   = r_sram_rw;
        w_sram_addr = r_sram_addr;
        w_sram_din  = r_sram_din;
        w_a_ack     = 1'b0;
        w_b_ack     = 1'b0;
        w_a_rdata   = r_a_rdata;
        w_b_rdata   = r_b_rdata;
        case (r_state)
            IDLE: begin
                if (r_clr_pend) begin
                    w_state_nxt = CLEAR;
                    w_clr_pend  = 1'b0;
                    w_cnt       = 15'd0;
                    w_sram_en   = 1'b1;
                    w_sram_rw   = 1'b1;
                    w_sram_addr = 15'd0;
                    w_sram_din  = 8'd0;
                end else if (A_Req && (!B_Req || r_last_b)) begin
                    w_state_nxt = ACCESS;
                    w_sel_b     = 1'b0;
                    w_last_b    = 1'b0;
                    w_sram_en   = 1'b1;
                    w_sram_rw   = A_Rw;
                    w_sram_addr = A_Addr;
                    w_sram_din  = A_Wdata;
                end else if (B_Req) begin
                    w_state_nxt = ACCESS;
                    w_sel_b     = 1'b1;
                    w_last_b    = 1'b1;
                    w_sram_en   = 1'b1;
                    w_sram_rw   = B_Rw;
                    w_sram_addr = B_Addr;
                    w_sram_din  = B_Wdata;
                end
            end
            ACCESS: begin
                // Latched Rw in the SRAM control register selects the write/read path.
                if (r_sram_rw) begin
                    w_state_nxt = DONE;
                    w_a_ack     = !r_sel_b;
                    w_b_ack     = r_sel_b;
                end else begin
                    w_state_nxt = RWAIT;
                end
            end
            RWAIT: begin
                w_state_nxt = DONE;
                w_a_ack     = !r_sel_b;
                w_b_ack     = r_sel_b;
                if (r_sel_b) w_b_rdata = Sram_Data_out;
                else         w_a_rdata = Sram_Data_out;
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            CLEAR: begin
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = IDLE;
                    w_cnt       = 15'd0;
                    w_clr_done  = 1'b1;
                    w_clr_busy  = 1'b0;
                end else begin
                    w_cnt       = r_cnt + 15'd1;
                    w_sram_en   = 1'b1;
                    w_sram_rw   = 1'b1;
                    w_sram_addr = r_cnt + 15'd1;
                    w_sram_din  = 8'd0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_sel_b     <= 1'b0;
            r_last_b    <= 1'b1;
            r_cnt       <= 15'd0;
            r_clr_pend  <= 1'b0;
            r_clr_busy  <= 1'b0;
            r_clr_done  <= 1'b0;
            r_sram_en   <= 1'b0;
            r_sram_rw   <= 1'b0;
            r_sram_addr <= 15'd0;
            r_sram_din  <= 8'd0;
            r_a_ack     <= 1'b0;
            r_b_ack     <= 1'b0;
            r_a_rdata   <= 8'd0;
            r_b_rdata   <= 8'd0;
        end else begin
            r_sel_b     <= w_sel_b;
            r_last_b    <= w_last_b;
            r_cnt       <= w_cnt;
            r_clr_pend  <= w_clr_pend;
            r_clr_busy  <= w_clr_busy;
            r_clr_done  <= w_clr_done;
            r_sram_en   <= w_sram_en;
            r_sram_rw   <= w_sram_rw;
            r_sram_addr <= w_sram_addr;
            r_sram_din  <= w_sram_din;
            r_a_ack     <= w_a_ack;
            r_b_ack     <= w_b_ack;
            r_a_rdata   <= w_a_rdata;
            r_b_rdata   <= w_b_rdata;
        end
    end

    assign A_Ack        = r_a_ack;
    assign B_Ack        = r_b_ack;
    assign A_Rdata      = r_a_rdata;
    assign B_Rdata      = r_b_rdata;
    assign Clr_busy     = r_clr_busy;
    assign Clr_done     = r_clr_done;
    assign Sram_En      = r_sram_en;
    assign Sram_Rw      = r_sram_rw;
    assign Sram_Addr    = r_sram_addr;
    assign Sram_Data_in = r_sram_din;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: bench-owned SRAM model plus a reference memory and round-robin model.
module tb_sram_arbiter;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        A_Req, A_Rw, B_Req, B_Rw;
    logic [14:0] A_Addr, B_Addr;
    logic [7:0]  A_Wdata, B_Wdata;
    logic        A_Ack, B_Ack;
    logic [7:0]  A_Rdata, B_Rdata;
    logic        Clr_start, Clr_busy, Clr_done;
    logic        Sram_En, Sram_Rw;
    logic [14:0] Sram_Addr;
    logic [7:0]  Sram_Data_in, Sram_Data_out;

    logic [7:0]  sram_mem [0:32767];
    logic [7:0]  ref_mem  [0:32767];
    logic [7:0]  sram_dout;
    bit          last_b;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 Clk = ~Clk;

    sram_arbiter dut (
        .Clk(Clk), .Rst(Rst),
        .A_Req(A_Req), .A_Rw(A_Rw), .A_Addr(A_Addr), .A_Wdata(A_Wdata),
        .A_Ack(A_Ack), .A_Rdata(A_Rdata),
        .B_Req(B_Req), .B_Rw(B_Rw), .B_Addr(B_Addr), .B_Wdata(B_Wdata),
        .B_Ack(B_Ack), .B_Rdata(B_Rdata),
        .Clr_start(Clr_start), .Clr_busy(Clr_busy), .Clr_done(Clr_done),
        .Sram_En(Sram_En), .Sram_Rw(Sram_Rw), .Sram_Addr(Sram_Addr),
        .Sram_Data_in(Sram_Data_in), .Sram_Data_out(Sram_Data_out)
    );

    // SRAM model: read data is valid only for the cycle after the sampling edge, garbage otherwise.
    assign Sram_Data_out = sram_dout;
    always @(posedge Clk) begin
        if (Sram_En && Sram_Rw) sram_mem[Sram_Addr] = Sram_Data_in;
        sram_dout <= (Sram_En && !Sram_Rw) ? sram_mem[Sram_Addr] : 8'($urandom);
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_access(input bit pb, input bit rw, input logic [14:0] ad, input logic [7:0] wd,
                             output int lat, output logic [7:0] rd);
        bit got = 0;
        if (pb) begin B_Req = 1; B_Rw = rw; B_Addr = ad; B_Wdata = wd; end
        else    begin A_Req = 1; A_Rw = rw; A_Addr = ad; A_Wdata = wd; end
        lat = 0;
        rd  = 8'hxx;
        while (!got && lat < 20) begin
            @(posedge Clk); lat++; @(negedge Clk);
            // Scramble request fields after the grant edge; the access must not notice.
            if (pb) begin B_Addr = 15'($urandom); B_Wdata = 8'($urandom); B_Rw = ~rw; end
            else    begin A_Addr = 15'($urandom); A_Wdata = 8'($urandom); A_Rw = ~rw; end
            if (pb ? B_Ack : A_Ack) begin
                got = 1;
                rd  = pb ? B_Rdata : A_Rdata;
            end
        end
        if (!got) lat = -1;
        A_Req = 0; B_Req = 0;
        @(posedge Clk); @(negedge Clk);
    endtask

    task automatic watch_clear(output int n_wr, output int n_bad, output int n_done,
                               output int n_ack, output bit timed_out);
        int cyc = 0;
        n_wr = 0; n_bad = 0; n_done = 0; n_ack = 0;
        while (n_done == 0 && cyc < 33000) begin
            @(posedge Clk); cyc++; @(negedge Clk);
            if (A_Ack || B_Ack) n_ack++;
            if (Clr_done) begin
                n_done++;
            end else begin
                if (!Clr_busy) n_bad++;
                if (Sram_En) begin
                    if (!Sram_Rw || Sram_Data_in !== 8'd0 || Sram_Addr !== 15'(n_wr)) n_bad++;
                    n_wr++;
                end else if (n_wr > 0) begin
                    n_bad++;
                end
            end
        end
        timed_out = (n_done == 0);
    endtask

    task automatic test_reset();
        Rst = 1; A_Req = 0; B_Req = 0; A_Rw = 0; B_Rw = 0; A_Addr = 0; B_Addr = 0;
        A_Wdata = 0; B_Wdata = 0; Clr_start = 0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        n_total++;
        if ({Sram_En, Sram_Rw, Sram_Addr, Sram_Data_in} !== 25'd0)
            $display("FAIL reset_sram: got %0h expected 0", {Sram_En, Sram_Rw, Sram_Addr, Sram_Data_in});
        else n_pass++;
        n_total++;
        if ({A_Ack, B_Ack, A_Rdata, B_Rdata} !== 18'd0)
            $display("FAIL reset_port: got %0h expected 0", {A_Ack, B_Ack, A_Rdata, B_Rdata});
        else n_pass++;
        n_total++;
        if ({Clr_busy, Clr_done} !== 2'b00)
            $display("FAIL reset_clr: got %b expected 00", {Clr_busy, Clr_done});
        else n_pass++;
        Rst = 0;
        last_b = 1;
        @(negedge Clk);
    endtask

    task automatic test_single_write();
        A_Req = 1; A_Rw = 1; A_Addr = 15'h0010; A_Wdata = 8'h5A;
        @(posedge Clk); @(negedge Clk);
        n_total++;
        if ({Sram_En, Sram_Rw, Sram_Addr, Sram_Data_in, A_Ack} !== {1'b1, 1'b1, 15'h0010, 8'h5A, 1'b0})
            $display("FAIL write_issue: got en=%b rw=%b addr=%0h d=%0h ack=%b expected 1 1 10 5a 0",
                     Sram_En, Sram_Rw, Sram_Addr, Sram_Data_in, A_Ack);
        else n_pass++;
        @(posedge Clk); @(negedge Clk);
        n_total++;
        if ({A_Ack, B_Ack, Sram_En} !== 3'b100)
            $display("FAIL write_ack: got ackA=%b ackB=%b en=%b expected 1 0 0", A_Ack, B_Ack, Sram_En);
        else n_pass++;
        A_Req = 0;
        @(posedge Clk); @(negedge Clk);
        n_total++;
        if (A_Ack !== 1'b0) $display("FAIL write_ack_pulse: got %b expected 0", A_Ack);
        else n_pass++;
        ref_mem[15'h0010] = 8'h5A;
        last_b = 0;
    endtask

    task automatic test_readback();
        int lat; logic [7:0] rd;
        do_access(0, 0, 15'h0010, 8'h00, lat, rd);
        n_total++;
        if (lat !== 3) $display("FAIL read_latency: got %0d expected 3", lat);
        else n_pass++;
        n_total++;
        if (rd !== ref_mem[15'h0010]) $display("FAIL read_data: got %0h expected %0h", rd, ref_mem[15'h0010]);
        else n_pass++;
        @(posedge Clk); @(negedge Clk);
        n_total++;
        if (A_Rdata !== 8'h5A || A_Ack !== 1'b0)
            $display("FAIL read_hold: got rdata=%0h ack=%b expected 5a 0", A_Rdata, A_Ack);
        else n_pass++;
        last_b = 0;
    endtask

    task automatic test_contention();
        int cyc = 0; int lat_a = -1; int lat_b = -1;
        Rst = 1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst = 0;
        last_b = 1;
        A_Req = 1; A_Rw = 1; A_Addr = 15'h0030; A_Wdata = 8'hA1;
        B_Req = 1; B_Rw = 1; B_Addr = 15'h0031; B_Wdata = 8'hB2;
        while ((lat_a < 0 || lat_b < 0) && cyc < 20) begin
            @(posedge Clk); cyc++; @(negedge Clk);
            if (A_Ack && lat_a < 0) begin lat_a = cyc; A_Req = 0; end
            if (B_Ack && lat_b < 0) begin lat_b = cyc; B_Req = 0; end
        end
        n_total++;
        if (lat_a !== 2) $display("FAIL contention_a: got ack edge %0d expected 2", lat_a);
        else n_pass++;
        n_total++;
        if (lat_b !== 5) $display("FAIL contention_b: got ack edge %0d expected 5", lat_b);
        else n_pass++;
        ref_mem[15'h0030] = 8'hA1;
        ref_mem[15'h0031] = 8'hB2;
        last_b = 1;
        @(posedge Clk); @(negedge Clk);
    endtask

    task automatic test_random();
        for (int it = 0; it < 60; it++) begin
            int mode; int lat; int cyc; int first; bit a_done; bit b_done; bit simul;
            logic arw, brw; logic [14:0] aad, bad; logic [7:0] awd, bwd, rd;
            mode = $urandom_range(0, 2);
            arw = 1'($urandom_range(0, 1)); brw = 1'($urandom_range(0, 1));
            aad = 15'h0100 + 15'($urandom_range(0, 7));
            bad = 15'h0100 + 15'($urandom_range(0, 7));
            awd = 8'($urandom); bwd = 8'($urandom);
            if (mode < 2) begin
                do_access(mode[0], arw, aad, awd, lat, rd);
                n_total++;
                if (lat !== (arw ? 2 : 3)) $display("FAIL rand_latency: got %0d expected %0d", lat, arw ? 2 : 3);
                else n_pass++;
                if (!arw) begin
                    n_total++;
                    if (rd !== ref_mem[aad]) $display("FAIL rand_read: addr %0h got %0h expected %0h", aad, rd, ref_mem[aad]);
                    else n_pass++;
                end else begin
                    ref_mem[aad] = awd;
                end
                last_b = mode[0];
            end else begin
                A_Req = 1; A_Rw = arw; A_Addr = aad; A_Wdata = awd;
                B_Req = 1; B_Rw = brw; B_Addr = bad; B_Wdata = bwd;
                a_done = 0; b_done = 0; first = -1; cyc = 0; simul = 0;
                while (!(a_done && b_done) && cyc < 30) begin
                    @(posedge Clk); cyc++; @(negedge Clk);
                    if (A_Ack && B_Ack) simul = 1;
                    if (A_Ack && !a_done) begin
                        a_done = 1; A_Req = 0;
                        if (first < 0) first = 0;
                        if (!arw) begin
                            n_total++;
                            if (A_Rdata !== ref_mem[aad]) $display("FAIL pair_read_a: got %0h expected %0h", A_Rdata, ref_mem[aad]);
                            else n_pass++;
                        end else ref_mem[aad] = awd;
                    end
                    if (B_Ack && !b_done) begin
                        b_done = 1; B_Req = 0;
                        if (first < 0) first = 1;
                        if (!brw) begin
                            n_total++;
                            if (B_Rdata !== ref_mem[bad]) $display("FAIL pair_read_b: got %0h expected %0h", B_Rdata, ref_mem[bad]);
                            else n_pass++;
                        end else ref_mem[bad] = bwd;
                    end
                end
                A_Req = 0; B_Req = 0;
                n_total++;
                if (!(a_done && b_done) || simul) $display("FAIL pair_acks: got a=%b b=%b same_cycle=%b expected 1 1 0", a_done, b_done, simul);
                else n_pass++;
                n_total++;
                if (first !== (last_b ? 0 : 1)) $display("FAIL pair_order: got first=%0d expected %0d", first, last_b ? 0 : 1);
                else n_pass++;
                last_b = (first == 0);
                @(posedge Clk); @(negedge Clk);
            end
        end
    endtask

    task automatic test_clear();
        int lat; logic [7:0] rd; int n_wr, n_bad, n_done, n_ack; bit to;
        do_access(0, 1, 15'h0000, 8'h11, lat, rd);
        do_access(1, 1, 15'h7FFF, 8'hEE, lat, rd);
        last_b = 1;
        Clr_start = 1;
        @(posedge Clk); @(negedge Clk);
        Clr_start = 0;
        n_total++;
        if (Clr_busy !== 1'b1) $display("FAIL clr_busy_rise: got %b expected 1", Clr_busy);
        else n_pass++;
        watch_clear(n_wr, n_bad, n_done, n_ack, to);
        n_total++;
        if (to || n_wr !== 32768 || n_bad !== 0)
            $display("FAIL clr_writes: got writes=%0d bad=%0d timeout=%b expected 32768 0 0", n_wr, n_bad, to);
        else n_pass++;
        n_total++;
        if (Clr_busy !== 1'b0 || Sram_En !== 1'b0) $display("FAIL clr_end: got busy=%b en=%b expected 0 0", Clr_busy, Sram_En);
        else n_pass++;
        @(posedge Clk); @(negedge Clk);
        n_total++;
        if (Clr_done !== 1'b0) $display("FAIL clr_done_pulse: got %b expected 0", Clr_done);
        else n_pass++;
        for (int i = 0; i < 32768; i++) ref_mem[i] = 8'h00;
        do_access(0, 0, 15'h0000, 8'h00, lat, rd);
        n_total++;
        if (rd !== 8'h00) $display("FAIL clr_rd_0000: got %0h expected 0", rd);
        else n_pass++;
        do_access(1, 0, 15'h0010, 8'h00, lat, rd);
        n_total++;
        if (rd !== 8'h00) $display("FAIL clr_rd_0010: got %0h expected 0", rd);
        else n_pass++;
        do_access(0, 0, 15'h7FFF, 8'h00, lat, rd);
        n_total++;
        if (rd !== 8'h00) $display("FAIL clr_rd_7fff: got %0h expected 0", rd);
        else n_pass++;
        last_b = 0;
    endtask

    task automatic test_clear_during_access();
        int lat; logic [7:0] rd; int n_wr, n_bad, n_done, n_ack; bit to; bit got = 0;
        do_access(0, 1, 15'h0010, 8'h77, lat, rd);
        ref_mem[15'h0010] = 8'h77;
        A_Req = 1; A_Rw = 0; A_Addr = 15'h0010;
        @(posedge Clk); @(negedge Clk);
        @(posedge Clk); @(negedge Clk);
        Clr_start = 1;
        @(posedge Clk); @(negedge Clk);
        Clr_start = 0;
        n_total++;
        if (A_Ack !== 1'b1 || A_Rdata !== 8'h77 || Clr_busy !== 1'b1)
            $display("FAIL cda_read: got ack=%b rdata=%0h busy=%b expected 1 77 1", A_Ack, A_Rdata, Clr_busy);
        else n_pass++;
        A_Req = 0;
        B_Req = 1; B_Rw = 1; B_Addr = 15'h0020; B_Wdata = 8'h33;
        watch_clear(n_wr, n_bad, n_done, n_ack, to);
        n_total++;
        if (to || n_wr !== 32768 || n_bad !== 0 || n_ack !== 0)
            $display("FAIL cda_clear: got writes=%0d bad=%0d acks=%0d timeout=%b expected 32768 0 0 0", n_wr, n_bad, n_ack, to);
        else n_pass++;
        lat = 0;
        while (!got && lat < 10) begin
            @(posedge Clk); lat++; @(negedge Clk);
            if (B_Ack) got = 1;
        end
        B_Req = 0;
        n_total++;
        if (!got || lat !== 2) $display("FAIL cda_b_ack: got ack=%b edge=%0d expected 1 2", got, lat);
        else n_pass++;
        @(posedge Clk); @(negedge Clk);
        for (int i = 0; i < 32768; i++) ref_mem[i] = 8'h00;
        ref_mem[15'h0020] = 8'h33;
        do_access(0, 0, 15'h0020, 8'h00, lat, rd);
        n_total++;
        if (rd !== ref_mem[15'h0020]) $display("FAIL cda_rd_0020: got %0h expected %0h", rd, ref_mem[15'h0020]);
        else n_pass++;
        do_access(1, 0, 15'h0010, 8'h00, lat, rd);
        n_total++;
        if (rd !== ref_mem[15'h0010]) $display("FAIL cda_rd_0010: got %0h expected %0h", rd, ref_mem[15'h0010]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_clear();
        bit found = 0; int cyc = 0; int n_done = 0; int n_en = 0;
        Clr_start = 1;
        @(posedge Clk); @(negedge Clk);
        Clr_start = 0;
        while (!found && cyc < 400) begin
            @(posedge Clk); cyc++; @(negedge Clk);
            if (Sram_En && Sram_Rw && Sram_Addr == 15'd100) found = 1;
        end
        n_total++;
        if (!found) $display("FAIL rmc_reach100: got not reached expected reached");
        else n_pass++;
        Rst = 1;
        @(posedge Clk); @(negedge Clk);
        Rst = 0;
        n_total++;
        if ({Sram_En, Clr_busy, Clr_done} !== 3'b000)
            $display("FAIL rmc_abort: got en=%b busy=%b done=%b expected 0 0 0", Sram_En, Clr_busy, Clr_done);
        else n_pass++;
        repeat (40) begin
            @(posedge Clk); @(negedge Clk);
            if (Clr_done) n_done++;
            if (Sram_En) n_en++;
        end
        n_total++;
        if (n_done !== 0 || n_en !== 0) $display("FAIL rmc_quiet: got done=%0d en=%0d expected 0 0", n_done, n_en);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) begin
            sram_mem[i] = 8'($urandom);
            ref_mem[i]  = sram_mem[i];
        end
        test_reset();
        test_single_write();
        test_readback();
        test_contention();
        test_random();
        test_clear();
        test_clear_during_access();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
